dmem_rmw_port: RTL and testbench

DMEM_RMW_PORT -- requirements
Module: dmem_rmw_port

---
 rtl/dmem_rmw_port_pkg.sv | 34 +++
 rtl/dmem_lane_fmt.sv | 40 ++++
 rtl/dmem_rmw_port.sv | 151 +++++++++++++++
 tb/tb_dmem_rmw_port.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_rmw_port_pkg.sv
// Shared constants for the data-memory read-modify-write port:
// the data width, the access-type codes, the FSM states and type decode helpers.
package dmem_rmw_port_pkg;

    localparam int DATAWIDTH = 32;

    // Access-type codes. Any code with bit 1 set is treated as a word access.
    localparam logic [2:0] TYPE_BYTE_S = 3'b000;
    localparam logic [2:0] TYPE_HALF_S = 3'b001;
    localparam logic [2:0] TYPE_WORD   = 3'b010;
    localparam logic [2:0] TYPE_BYTE_U = 3'b100;
    localparam logic [2:0] TYPE_HALF_U = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    function automatic logic is_word(input logic [2:0] t);
        return t[1];
    endfunction

    function automatic logic is_half(input logic [2:0] t);
        return !t[1] && t[0];
    endfunction

    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] lo);
        return (is_half(t) && lo[0]) || (is_word(t) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane logic: merges store data into the addressed lane of a
// RAM word and extracts/extends the addressed lane of a RAM word for loads.
module dmem_lane_fmt
    import dmem_rmw_port_pkg::*;
(
    input  logic [2:0]           i_type,
    input  logic [1:0]           i_lo,
    input  logic [DATAWIDTH-1:0] i_rdata,
    input  logic [DATAWIDTH-1:0] i_wdata,
    output logic [DATAWIDTH-1:0] o_merged,
    output logic [DATAWIDTH-1:0] o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_rdata[{i_lo, 3'b000} +: 8];
        w_half   = i_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_load   = i_rdata;
        o_merged = i_wdata;
        if (is_word(i_type)) begin
            o_load   = i_rdata;
            o_merged = i_wdata;
        end else if (is_half(i_type)) begin
            o_load   = i_type[2] ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            o_merged = i_rdata;
            if (i_lo[1]) begin
                o_merged[31:16] = i_wdata[15:0];
            end else begin
                o_merged[15:0] = i_wdata[15:0];
            end
        end else begin
            o_load   = i_type[2] ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            o_merged = i_rdata;
            o_merged[{i_lo, 3'b000} +: 8] = i_wdata[7:0];
        end
    end

endmodule

// File: rtl/dmem_rmw_port.sv
// CPU data-memory port onto a word RAM without byte enables; narrow stores are
// done as read-modify-write. Handshake: a request is taken on a rising edge where req_valid && req_ready.
module dmem_rmw_port
    import dmem_rmw_port_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = DATAWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output state_t            dbg_state
);

    state_t              r_state;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic [2:0]          r_type_q;
    logic                r_we_q;
    logic [ADDR_W+1:0]   r_addr_q;
    logic [DATA_W-1:0]   r_wdata_q;

    logic                w_accept;
    logic                w_misaligned;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_load_ext;
    logic                w_unused_addr;

    assign w_accept      = req_valid && r_req_ready;
    assign w_misaligned  = is_misaligned(req_type, req_addr[1:0]);
    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    dmem_lane_fmt u_lane_fmt (
        .i_type   (r_type_q),
        .i_lo     (r_addr_q[1:0]),
        .i_rdata  (ram_rdata),
        .i_wdata  (r_wdata_q),
        .o_merged (w_merged),
        .o_load   (w_load_ext)
    );

    // Outputs are registered and updated together with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_type_q    <= '0;
            r_we_q      <= 1'b0;
            r_addr_q    <= '0;
            r_wdata_q   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_type_q    <= req_type;
                        r_we_q      <= req_we;
                        r_addr_q    <= req_addr[ADDR_W+1:0];
                        r_wdata_q   <= req_wdata;
                        r_req_ready <= 1'b0;
                        r_rsp_rdata <= '0;
                        if (w_misaligned) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (req_we && is_word(req_type)) begin
                            r_state     <= ST_WR;
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= 1'b1;
                            r_ram_wdata <= req_wdata;
                        end else begin
                            r_state  <= ST_RD;
                            r_ram_en <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    r_state  <= ST_CAP;
                    r_ram_en <= 1'b0;
                end
                // RAM read data is valid during CAP; it is consumed directly here.
                ST_CAP: begin
                    if (r_we_q) begin
                        r_state     <= ST_WR;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= 1'b1;
                        r_ram_wdata <= w_merged;
                    end else begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load_ext;
                    end
                end
                ST_WR: begin
                    r_state     <= ST_RESP;
                    r_ram_en    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_ram_en    <= 1'b0;
                    r_ram_we    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_addr_q[ADDR_W+1:2];
    assign ram_wdata = r_ram_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_rmw_port.sv
// Directed and random checks of dmem_rmw_port against a behavioural word RAM
// and a reference model of lane extraction and merging.
module tb_dmem_rmw_port;
    import dmem_rmw_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_en;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    state_t      dbg_state;

    logic [31:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr = 10'h0;
    logic [31:0] pre_data = 32'h0;
    int          we_cnt = 0;
    int          en_cnt = 0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_err_q[$];
    logic [31:0] exp_lat_q[$];

    dmem_rmw_port #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // word RAM, 1-cycle synchronous read, plus a preload path for the bench
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (ram_en) en_cnt <= en_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] t, input logic [1:0] lo);
        logic [31:0] sh;
        logic [15:0] h;
        logic [7:0]  b;
        sh = w >> {lo, 3'b000};
        h  = sh[15:0];
        b  = sh[7:0];
        if (t[1]) return w;
        if (t[0]) return t[2] ? {16'h0, h} : {{16{h[15]}}, h};
        return t[2] ? {24'h0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] t, input logic [1:0] lo,
                                              input logic [31:0] wd);
        logic [31:0] mask;
        if (t[1]) return wd;
        if (t[0]) return lo[1] ? {wd[15:0], w[15:0]} : {w[31:16], wd[15:0]};
        mask = 32'h0000_00FF << {lo, 3'b000};
        return (w & ~mask) | ((wd & 32'h0000_00FF) << {lo, 3'b000});
    endfunction

    task automatic preload(input int widx, input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = widx[9:0];
        pre_data = d;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    // driver + scoreboard for one access; expectations are queued at acceptance
    task automatic do_access(input string tag, input logic we, input logic [2:0] t, input logic [31:0] addr,
                             input logic [31:0] wd, input int lat, input logic [31:0] rd, input logic err);
        int n;
        logic seen;
        @(negedge clk);
        check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        exp_q.push_back(rd);
        exp_err_q.push_back({31'h0, err});
        exp_lat_q.push_back(lat);
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        req_type  = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
        n    = 1;
        seen = 1'b0;
        while (!seen && n <= 8) begin
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check({tag, "_seen"}, {31'h0, seen}, 32'h1);
        check({tag, "_lat"}, n, exp_lat_q.pop_front());
        check({tag, "_rdata"}, rsp_rdata, exp_q.pop_front());
        check({tag, "_err"}, {31'h0, rsp_err}, exp_err_q.pop_front());
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        int we0, en0, hits;
        logic [31:0] model [4:7];

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        check("rst_ram_we", {31'h0, ram_we}, 32'h0);
        check("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // byte store read-modify-write
        preload(1, 32'h1122_3344);
        do_access("sb6", 1'b1, TYPE_BYTE_S, 32'h6, 32'h0000_00AB, 4, 32'h0, 1'b0);
        check("sb6_mem", mem[1], 32'h11AB_3344);

        // signed / unsigned byte and half loads
        preload(1, 32'h8000_FF7F);
        do_access("lb5", 1'b0, TYPE_BYTE_S, 32'h5, 32'h0, 3, 32'hFFFF_FFFF, 1'b0);
        do_access("lbu5", 1'b0, TYPE_BYTE_U, 32'h5, 32'h0, 3, 32'h0000_00FF, 1'b0);
        do_access("lb4", 1'b0, TYPE_BYTE_S, 32'h4, 32'h0, 3, 32'h0000_007F, 1'b0);
        do_access("lh6", 1'b0, TYPE_HALF_S, 32'h6, 32'h0, 3, 32'hFFFF_8000, 1'b0);
        do_access("lhu6", 1'b0, TYPE_HALF_U, 32'h6, 32'h0, 3, 32'h0000_8000, 1'b0);
        do_access("sh4", 1'b1, TYPE_HALF_S, 32'h4, 32'h1234_BEEF, 4, 32'h0, 1'b0);
        check("sh4_mem", mem[1], 32'h8000_BEEF);
        do_access("lw4", 1'b0, 3'b111, 32'h4, 32'h0, 3, 32'h8000_BEEF, 1'b0);

        // word store: single write pulse
        preload(2, 32'h0000_0000);
        we0 = we_cnt;
        do_access("sw8", 1'b1, TYPE_WORD, 32'h8, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        check("sw8_mem", mem[2], 32'hDEAD_BEEF);
        check("sw8_we_pulses", we_cnt - we0, 32'd1);

        // misaligned accesses never touch the RAM
        en0 = en_cnt;
        do_access("lh3", 1'b0, TYPE_HALF_S, 32'h3, 32'h0, 1, 32'h0, 1'b1);
        do_access("swA", 1'b1, TYPE_WORD, 32'hA, 32'h5555_AAAA, 1, 32'h0, 1'b1);
        check("mis_ram_en", en_cnt - en0, 32'd0);
        check("mis_mem2", mem[2], 32'hDEAD_BEEF);
        check("mis_mem0", mem[0], mem[0] === 32'h5555_AAAA ? 32'h0 : mem[0]);

        // random narrow/word traffic against the reference model
        for (int i = 4; i <= 7; i++) begin
            model[i] = $urandom;
            preload(i, model[i]);
        end
        for (int k = 0; k < 16; k++) begin
            logic [2:0]  t;
            logic [1:0]  lo;
            logic        we;
            int          wi;
            int          lat;
            logic [31:0] wd;
            case ($urandom_range(0, 4))
                0: t = TYPE_BYTE_S;
                1: t = TYPE_BYTE_U;
                2: t = TYPE_HALF_S;
                3: t = TYPE_HALF_U;
                default: t = TYPE_WORD;
            endcase
            lo = 2'($urandom_range(0, 3));
            if (t[1]) lo = 2'b00;
            else if (t[0]) lo[0] = 1'b0;
            we = 1'($urandom_range(0, 1));
            wi = $urandom_range(4, 7);
            wd = $urandom;
            if (!we) lat = 3;
            else if (t[1]) lat = 2;
            else lat = 4;
            if (we) begin
                model[wi] = ref_store(model[wi], t, lo, wd);
                do_access("rnd_st", 1'b1, t, {wi[29:0], lo}, wd, lat, 32'h0, 1'b0);
                check("rnd_st_mem", mem[wi], model[wi]);
            end else begin
                do_access("rnd_ld", 1'b0, t, {wi[29:0], lo}, wd, lat, ref_load(model[wi], t, lo), 1'b0);
            end
        end

        // reset during CAP of a byte store aborts it
        preload(3, 32'hCAFE_F00D);
        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_type  = TYPE_BYTE_U;
        req_addr  = 32'hC;
        req_wdata = 32'h0000_0011;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_in_cap", {29'h0, dbg_state}, {29'h0, ST_CAP});
        rst = 1'b1;
        #1;
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        check("abort_ram_we", {31'h0, ram_we}, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        hits = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rsp_valid) hits++;
        end
        check("abort_no_rsp", hits, 32'd0);
        check("abort_no_we", we_cnt - we0, 32'd0);
        check("abort_mem3", mem[3], 32'hCAFE_F00D);

        // reset while WR is driving the write
        preload(8, 32'h0123_4567);
        we0 = we_cnt;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_type  = TYPE_WORD;
        req_addr  = 32'h20;
        req_wdata = 32'h7777_7777;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("wr_in_wr", {29'h0, dbg_state}, {29'h0, ST_WR});
        rst = 1'b1;
        #1;
        check("wr_abort_we", {31'h0, ram_we}, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        hits = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (rsp_valid) hits++;
        end
        check("wr_abort_no_rsp", hits, 32'd0);
        check("wr_abort_mem8", mem[8], 32'h0123_4567);
        check("wr_abort_no_we", we_cnt - we0, 32'd0);

        // the port keeps working after an abort
        do_access("post_lw", 1'b0, TYPE_WORD, 32'h20, 32'h0, 3, 32'h0123_4567, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
